// File: rtl/systolic_tile_feeder.sv
// Tile sequencer for a systolic array: weight shift-in, one-cycle latch, skewed activation
// stream, zero-fill drain and a single capture pulse.
module systolic_tile_feeder #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DRAIN_CYC = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               accumulate_in,
    input  logic [CNT_W-1:0]   vec_count,
    input  logic               w_valid,
    input  logic [ROWS*DW-1:0] w_data,
    output logic               w_ready,
    input  logic               a_valid,
    input  logic [ROWS*DW-1:0] a_data,
    output logic               a_ready,
    output logic               enable_cycle,
    output logic               load_W,
    output logic               accumulate_mode,
    output logic               capture_en,
    output logic [ROWS*DW-1:0] row_inputs,
    output logic               busy,
    output logic               done
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        StIdle, StLoadW, StLatch, StStream, StDrain, StCapture, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               acc_q, acc_d;
    // hist_q[i] holds the vector pushed i+1 enabled cycles ago; row r reads hist_q[r-1].
    logic [ROWS*DW-1:0] hist_q [ROWS-1];
    logic [ROWS*DW-1:0] hist_d [ROWS-1];
    logic               shift;
    logic [ROWS*DW-1:0] shift_in;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        k_d             = k_q;
        acc_d           = acc_q;
        hist_d          = hist_q;
        shift           = 1'b0;
        shift_in        = '0;
        w_ready         = 1'b0;
        a_ready         = 1'b0;
        enable_cycle    = 1'b0;
        load_W          = 1'b0;
        accumulate_mode = 1'b0;
        capture_en      = 1'b0;
        row_inputs      = '0;
        done            = 1'b0;
        busy            = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start && (vec_count != '0)) begin
                    state_d = StLoadW;
                    k_d     = vec_count;
                    acc_d   = accumulate_in;
                    cnt_d   = '0;
                end
            end
            StLoadW: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    enable_cycle = 1'b1;
                    row_inputs   = w_data;
                    if (cnt_q == CW'(ROWS - 1)) begin
                        cnt_d   = '0;
                        state_d = StLatch;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StLatch: begin
                load_W       = 1'b1;
                enable_cycle = 1'b1;
                state_d      = StStream;
            end
            StStream: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    enable_cycle = 1'b1;
                    shift        = 1'b1;
                    shift_in     = a_data;
                    if (cnt_q == CW'(k_q) - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                enable_cycle = 1'b1;
                shift        = 1'b1;
                if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCapture: begin
                capture_en      = 1'b1;
                accumulate_mode = acc_q;
                state_d         = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Skew lines advance only with the array so stalls keep the wavefront aligned.
        if (shift) begin
            row_inputs[0 +: DW] = shift_in[0 +: DW];
            for (int r = 1; r < int'(ROWS); r++) begin
                row_inputs[r*DW +: DW] = hist_q[r-1][r*DW +: DW];
            end
            hist_d[0] = shift_in;
            for (int i = 1; i < int'(ROWS) - 1; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            acc_q   <= 1'b0;
            for (int i = 0; i < int'(ROWS) - 1; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            for (int i = 0; i < int'(ROWS) - 1; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end
endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Bench for systolic_tile_feeder: per-tile expected enabled-cycle row stream built from the
// skew rule, plus pulse counts, capture mode, latency and ignored-start checks.
module tb_systolic_tile_feeder;
    localparam int ROWS  = 8;
    localparam int DW    = 8;
    localparam int CNT_W = 8;
    localparam int DRAIN = 24;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, accumulate_in;
    logic [CNT_W-1:0]   vec_count;
    logic               w_valid, w_ready, a_valid, a_ready;
    logic [ROWS*DW-1:0] w_data, a_data, row_inputs;
    logic               enable_cycle, load_W, accumulate_mode, capture_en, busy, done;

    int checks   = 0;
    int failures = 0;

    systolic_tile_feeder #(
        .ROWS(ROWS), .DW(DW), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate_in(accumulate_in),
        .vec_count(vec_count), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready), .enable_cycle(enable_cycle),
        .load_W(load_W), .accumulate_mode(accumulate_mode), .capture_en(capture_en),
        .row_inputs(row_inputs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({w_ready, a_ready, enable_cycle, load_W, accumulate_mode,
                                capture_en, busy, done}), 64'(0));
        chk({tag, "_rows"}, row_inputs, 64'(0));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // wbyte/abyte of 0 select random data; abort_at >= 0 resets once that many vectors went in.
    task automatic run_tile(input int k, input bit acc, input logic [7:0] wbyte,
                            input logic [7:0] abyte, input int stall_pct, input int abort_at,
                            input bit noisy_start);
        logic [63:0] wv [ROWS];
        logic [63:0] av [$];
        logic [63:0] exp_q [$];
        logic [63:0] v;
        int wi = 0, ai = 0, cyc = 0, first = -1, en_idx = 0;
        int nload = 0, ncap = 0, ndone = 0;
        bit fin = 0;

        for (int i = 0; i < ROWS; i++) wv[i] = (wbyte != 0) ? {8{wbyte}} : rnd64();
        for (int i = 0; i < k; i++) av.push_back((abyte != 0) ? {8{abyte}} : rnd64());
        for (int i = 0; i < ROWS; i++) exp_q.push_back(wv[i]);
        exp_q.push_back(64'(0));
        for (int j = 0; j < k + DRAIN; j++) begin
            v = '0;
            for (int r = 0; r < ROWS; r++)
                if (j - r >= 0 && j - r < k) v[r*DW +: DW] = av[j-r][r*DW +: DW];
            exp_q.push_back(v);
        end

        @(negedge clk);
        start = 1'b1; accumulate_in = acc; vec_count = CNT_W'(k);
        #1 chk("busy_before_start", 64'(busy), 64'(0));
        @(posedge clk);

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            start         = noisy_start ? 1'($urandom % 2) : 1'b0;
            vec_count     = CNT_W'($urandom_range(0, 255));
            accumulate_in = 1'($urandom % 2);
            w_valid       = ($urandom_range(0, 99) >= stall_pct);
            w_data        = (wi < ROWS) ? wv[wi] : rnd64();
            a_valid       = ($urandom_range(0, 99) >= stall_pct);
            a_data        = (ai < k) ? av[ai] : rnd64();
            #1;
            if (abort_at >= 0 && a_ready && ai == abort_at) begin
                start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
                rst_n = 1'b0;
                #1 chk_all_zero("abort_outputs");
                chk("abort_no_capture", 64'(ncap), 64'(0));
                @(negedge clk);
                rst_n = 1'b1;
                #1 chk_all_zero("after_abort");
                return;
            end
            chk("busy_in_tile", 64'(busy), 64'(1));
            chk("ready_exclusive", 64'(w_ready & a_ready), 64'(0));
            if (w_valid && w_ready && first < 0) first = cyc;
            if (enable_cycle) begin
                if (exp_q.size() == 0) chk("extra_enable", 64'(1), 64'(0));
                else chk("row_inputs", row_inputs, exp_q.pop_front());
                en_idx++;
            end else begin
                chk("row_inputs_idle", row_inputs, 64'(0));
            end
            if (load_W) begin
                nload++;
                chk("load_W_position", 64'(en_idx - 1), 64'(ROWS));
                chk("load_W_enable", 64'(enable_cycle), 64'(1));
            end
            if (capture_en) begin
                ncap++;
                chk("capture_mode", 64'(accumulate_mode), 64'(acc));
                chk("capture_after_drain", 64'(exp_q.size()), 64'(0));
                chk("capture_no_enable", 64'(enable_cycle), 64'(0));
            end else begin
                chk("mode_outside_capture", 64'(accumulate_mode), 64'(0));
            end
            if (done) begin
                ndone++;
                fin = 1;
                if (stall_pct == 0)
                    chk("latency", 64'(cyc - first + 1), 64'(ROWS + 1 + k + DRAIN + 2));
            end
            if (w_valid && w_ready) wi++;
            if (a_valid && a_ready) ai++;
            cyc++;
        end
        chk("tile_finished", 64'(fin), 64'(1));
        chk("w_beats", 64'(wi), 64'(ROWS));
        chk("a_beats", 64'(ai), 64'(k));
        chk("load_W_count", 64'(nload), 64'(1));
        chk("capture_count", 64'(ncap), 64'(1));
        chk("done_count", 64'(ndone), 64'(1));
        @(negedge clk);
        start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        #1 chk_all_zero("idle_after_done");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; accumulate_in = 1'b0; vec_count = '0;
        w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
        #12 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start with zero vectors is ignored
        start = 1'b1; vec_count = '0; accumulate_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk_all_zero("start_k0");
        end
        start = 1'b0;

        run_tile(8, 1'b0, 8'h01, 8'h02, 0, -1, 1'b0);
        run_tile(8, 1'b1, 8'h01, 8'h04, 0, -1, 1'b1);
        run_tile(8, 1'b0, 8'h01, 8'h02, 50, -1, 1'b0);
        run_tile(1, 1'b1, 8'h00, 8'h00, 0, -1, 1'b1);
        for (int t = 0; t < 4; t++)
            run_tile($urandom_range(1, 20), 1'($urandom % 2), 8'h00, 8'h00, 30, -1, 1'b1);
        run_tile(8, 1'b0, 8'h00, 8'h00, 0, 4, 1'b0);
        run_tile(8, 1'b1, 8'h00, 8'h00, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
